// File: rtl/if_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl_if
// Brief    : Instruction-memory request/ready handshake between the fetch
//            sequencer (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : Instruction-fetch sequencer. Owns the PC, drives the imem
//            request/ready handshake, registers the IF/ID boundary and
//            produces the per-stage stall vector {wb,mem,ex,id,if,pc}.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall_req_id,
    input  wire logic        stall_req_ex,
    input  wire logic        branch_flag_i,
    input  wire logic [31:0] branch_target_i,
    input  wire logic        flush_i,
    input  wire logic [31:0] new_pc_i,
    output logic      [31:0] pc_o,
    output logic      [31:0] id_pc_o,
    output logic      [31:0] inst_o,
    output logic             inst_valid_o,
    output logic      [5:0]  stall_o,
    if_fetch_ctrl_if.master  imem
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_KILL = 2'd2;

    localparam logic [5:0] c_STALL_NONE = 6'b000000;
    localparam logic [5:0] c_STALL_EX   = 6'b001111;
    localparam logic [5:0] c_STALL_ID   = 6'b000111;
    localparam logic [5:0] c_STALL_MEM  = 6'b000011;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
    logic [31:0] r_id_pc;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic        r_inst_valid;
    logic        w_inst_valid_nxt;

    logic [5:0]  w_stall;
    logic        w_busy;
    logic        w_accept;
    logic        w_branch;
    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;

    // A request is outstanding in every state except IDLE.
    assign w_busy = (r_state == S_REQ) || (r_state == S_KILL);

    // Stall vector: first matching source wins; flush clears everything.
    always_comb begin
        w_stall = c_STALL_NONE;
        if (flush_i) begin
            w_stall = c_STALL_NONE;
        end else if (stall_req_ex) begin
            w_stall = c_STALL_EX;
        end else if (stall_req_id) begin
            w_stall = c_STALL_ID;
        end else if (w_busy && !imem.imem_ready_i) begin
            w_stall = c_STALL_MEM;
        end
    end

    // A branch is only trusted when ID itself is not being held.
    assign w_accept     = imem.imem_ready_i && !w_stall[1];
    assign w_branch     = branch_flag_i && !w_stall[2];
    assign w_redirect   = flush_i || w_branch;
    assign w_target_raw = flush_i ? new_pc_i : branch_target_i;
    assign w_target     = {w_target_raw[31:2], 2'b00};

    // Next-state and PC/pending selection. A redirect that arrives while the
    // memory has not answered cannot cancel the request, so the target is
    // parked and the stale response is swallowed in KILL.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pending_nxt = r_pending;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_redirect) begin
                    if (w_accept) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pending_nxt = w_target;
                        w_state_nxt   = S_KILL;
                    end
                end else if (w_accept) begin
                    w_pc_nxt = r_pc + 32'd4;
                end
            end
            S_KILL: begin
                if (flush_i) begin
                    w_pending_nxt = w_target;
                end
                if (w_accept) begin
                    w_pc_nxt    = flush_i ? w_target : r_pending;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // IF/ID boundary: hold when ID stalls, bubble when only IF stalls or on
    // flush, load only a genuinely accepted sequential fetch.
    always_comb begin
        w_id_pc_nxt      = r_id_pc;
        w_inst_nxt       = r_inst;
        w_inst_valid_nxt = r_inst_valid;
        if (flush_i || (w_stall[1] && !w_stall[2])) begin
            w_inst_nxt       = 32'h0;
            w_inst_valid_nxt = 1'b0;
        end else if (w_stall[1]) begin
            w_inst_valid_nxt = r_inst_valid;
        end else if ((r_state == S_REQ) && w_accept && !w_redirect) begin
            w_inst_nxt       = imem.imem_data_i;
            w_id_pc_nxt      = r_pc;
            w_inst_valid_nxt = 1'b1;
        end else begin
            w_inst_nxt       = 32'h0;
            w_inst_valid_nxt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, pending target and IF/ID registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_pending    <= 32'h0;
            r_id_pc      <= 32'h0;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_pending    <= w_pending_nxt;
            r_id_pc      <= w_id_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    assign imem.imem_req_o  = w_busy;
    assign imem.imem_addr_o = r_pc;
    assign pc_o             = r_pc;
    assign id_pc_o          = r_id_pc;
    assign inst_o           = r_inst;
    assign inst_valid_o     = r_inst_valid;
    assign stall_o          = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Brief    : Self-checking bench for if_fetch_ctrl: directed scenarios plus a
//            randomized run against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_id;
    logic        stall_req_ex;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [31:0] pc_o;
    logic [31:0] id_pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [5:0]  stall_o;

    int n_chk  = 0;
    int n_pass = 0;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_req_id    (stall_req_id),
        .stall_req_ex    (stall_req_ex),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .pc_o            (pc_o),
        .id_pc_o         (id_pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .stall_o         (stall_o),
        .imem            (bus.master)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    // Apply one cycle of inputs (called just after a falling edge).
    task automatic drive(input logic r, input logic ex, input logic id, input logic br,
                         input logic [31:0] b_t, input logic f, input logic [31:0] n_p,
                         input logic rdy);
        rst             = r;
        stall_req_ex    = ex;
        stall_req_id    = id;
        branch_flag_i   = br;
        branch_target_i = b_t;
        flush_i         = f;
        new_pc_i        = n_p;
        bus.imem_ready_i = rdy;
        bus.imem_data_i  = rdy ? mem_word(bus.imem_addr_o) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        n_chk++; if (pc_o !== 32'h0) $display("FAIL reset_pc got %h want 0", pc_o); else n_pass++;
        n_chk++; if (bus.imem_req_o !== 1'b0) $display("FAIL reset_req got %b want 0", bus.imem_req_o); else n_pass++;
        n_chk++; if (id_pc_o !== 32'h0 || inst_o !== 32'h0) $display("FAIL reset_ifid got %h/%h want 0/0", id_pc_o, inst_o); else n_pass++;
        n_chk++; if (inst_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid_o); else n_pass++;
        n_chk++; if (stall_o !== 6'b0) $display("FAIL reset_stall got %b want 000000", stall_o); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++; if (bus.imem_req_o !== 1'b0) $display("FAIL first_cycle_req got %b want 0", bus.imem_req_o); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (bus.imem_addr_o !== 32'(4 * k) || bus.imem_req_o !== 1'b1)
                $display("FAIL seq_addr[%0d] got %h req %b want %h req 1", k, bus.imem_addr_o, bus.imem_req_o, 4 * k);
            else n_pass++;
            n_chk++; if (inst_valid_o !== (k > 0)) $display("FAIL seq_valid[%0d] got %b want %b", k, inst_valid_o, k > 0); else n_pass++;
            if (k > 0) begin
                n_chk++; if (id_pc_o !== 32'(4 * (k - 1)) || inst_o !== mem_word(32'(4 * (k - 1))))
                    $display("FAIL seq_ifid[%0d] got %h/%h want %h/%h", k, id_pc_o, inst_o, 4 * (k - 1), mem_word(32'(4 * (k - 1))));
                else n_pass++;
            end
            if (k < 4) begin
                drive(0, 0, 0, 0, 0, 0, 0, 1);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_wait();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            n_chk++; if (stall_o !== 6'b000011) $display("FAIL wait_stall[%0d] got %b want 000011", i, stall_o); else n_pass++;
            @(negedge clk);
            n_chk++; if (bus.imem_addr_o !== 32'h10 || inst_valid_o !== 1'b0)
                $display("FAIL wait_hold[%0d] got %h/%b want 00000010/0", i, bus.imem_addr_o, inst_valid_o);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h14 || id_pc_o !== 32'h10 || inst_valid_o !== 1'b1)
            $display("FAIL wait_resume got %h/%h/%b want 14/10/1", bus.imem_addr_o, id_pc_o, inst_valid_o);
        else n_pass++;
    endtask

    task automatic test_ex_stall();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 1);
            n_chk++; if (stall_o !== 6'b001111) $display("FAIL ex_stall[%0d] got %b want 001111", i, stall_o); else n_pass++;
            @(negedge clk);
            n_chk++; if (pc_o !== 32'h14 || id_pc_o !== 32'h10 || inst_o !== mem_word(32'h10) || inst_valid_o !== 1'b1)
                $display("FAIL ex_hold[%0d] got pc %h idpc %h inst %h v %b", i, pc_o, id_pc_o, inst_o, inst_valid_o);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++; if (pc_o !== 32'h18 || id_pc_o !== 32'h14) $display("FAIL ex_resume got %h/%h want 18/14", pc_o, id_pc_o); else n_pass++;
    endtask

    task automatic test_branch_kill();
        int guard = 0;
        while (bus.imem_addr_o !== 32'h20 && guard < 16) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            guard++;
        end
        n_chk++; if (bus.imem_addr_o !== 32'h20) $display("FAIL br_reach got %h want 00000020", bus.imem_addr_o); else n_pass++;
        drive(0, 0, 0, 1, 32'h103, 0, 0, 0);
        n_chk++; if (stall_o !== 6'b000011) $display("FAIL br_stall got %b want 000011", stall_o); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h20 || bus.imem_req_o !== 1'b1 || inst_valid_o !== 1'b0)
            $display("FAIL kill_hold got %h/%b/%b want 20/1/0", bus.imem_addr_o, bus.imem_req_o, inst_valid_o);
        else n_pass++;
        drive(0, 0, 0, 1, 32'h200, 0, 0, 0);
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h20) $display("FAIL kill_hold2 got %h want 00000020", bus.imem_addr_o); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h100 || inst_valid_o !== 1'b0)
            $display("FAIL kill_redirect got %h/%b want 100/0", bus.imem_addr_o, inst_valid_o);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h104 || id_pc_o !== 32'h100 || inst_valid_o !== 1'b1)
            $display("FAIL br_target_fetch got %h/%h/%b want 104/100/1", bus.imem_addr_o, id_pc_o, inst_valid_o);
        else n_pass++;
    endtask

    task automatic test_flush_priority();
        drive(0, 0, 0, 1, 32'h200, 1, 32'h180, 1);
        n_chk++; if (stall_o !== 6'b0) $display("FAIL flush_stall got %b want 000000", stall_o); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h180 || inst_valid_o !== 1'b0)
            $display("FAIL flush_prio got %h/%b want 180/0", bus.imem_addr_o, inst_valid_o);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h184 || id_pc_o !== 32'h180)
            $display("FAIL flush_fetch got %h/%h want 184/180", bus.imem_addr_o, id_pc_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got %h want fffffffc", bus.imem_addr_o); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++; if (bus.imem_addr_o !== 32'h0 || id_pc_o !== 32'hFFFF_FFFC || inst_o !== mem_word(32'hFFFF_FFFC))
            $display("FAIL wrap got %h/%h/%h want 0/fffffffc/%h", bus.imem_addr_o, id_pc_o, inst_o, mem_word(32'hFFFF_FFFC));
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4)
            $display("FAIL midrst_setup got %b/%h want 1/4", bus.imem_req_o, bus.imem_addr_o);
        else n_pass++;
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++; if (bus.imem_req_o !== 1'b0 || pc_o !== 32'h0 || inst_valid_o !== 1'b0)
            $display("FAIL midrst got req %b pc %h v %b want 0/0/0", bus.imem_req_o, pc_o, inst_valid_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        m_act, m_kill, m_hold, m_valid;
        logic [31:0] m_pc, m_pend, m_idpc, m_inst;
        logic        r, ex, id, br, f, rdy, acc, br_ok, red;
        logic [31:0] bt, np, tgt;
        logic [5:0]  s;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        m_act = 0; m_kill = 0; m_hold = 0; m_valid = 0;
        m_pc = 0; m_pend = 0; m_idpc = 0; m_inst = 0;
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            n_chk++; if (pc_o !== m_pc || bus.imem_addr_o !== m_pc)
                $display("FAIL rnd_pc[%0d] got %h/%h want %h", c, pc_o, bus.imem_addr_o, m_pc);
            else n_pass++;
            n_chk++; if (bus.imem_req_o !== m_act) $display("FAIL rnd_req[%0d] got %b want %b", c, bus.imem_req_o, m_act); else n_pass++;
            n_chk++; if (inst_valid_o !== m_valid) $display("FAIL rnd_valid[%0d] got %b want %b", c, inst_valid_o, m_valid); else n_pass++;
            n_chk++; if (id_pc_o !== m_idpc || inst_o !== m_inst)
                $display("FAIL rnd_ifid[%0d] got %h/%h want %h/%h", c, id_pc_o, inst_o, m_idpc, m_inst);
            else n_pass++;

            r   = ($urandom_range(0, 79) == 0);
            ex  = ($urandom_range(0, 5) == 0);
            id  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 9) == 0);
            bt  = $urandom;
            np  = $urandom;
            rdy = m_hold || ($urandom_range(0, 1) == 1);
            drive(r, ex, id, br, bt, f, np, rdy);

            // Expected stall: first matching source.
            if (f)                 s = 6'b000000;
            else if (ex)           s = 6'b001111;
            else if (id)           s = 6'b000111;
            else if (m_act && !rdy) s = 6'b000011;
            else                   s = 6'b000000;
            n_chk++; if (stall_o !== s) $display("FAIL rnd_stall[%0d] got %b want %b", c, stall_o, s); else n_pass++;

            acc   = m_act && rdy && !s[1];
            br_ok = br && !s[2];
            red   = f || br_ok;
            tgt   = (f ? np : bt) & ~32'h3;
            if (r) begin
                m_act = 0; m_kill = 0; m_hold = 0; m_valid = 0;
                m_pc = 0; m_pend = 0; m_idpc = 0; m_inst = 0;
            end else begin
                if (f || (s[1] && !s[2])) begin
                    m_valid = 0; m_inst = 0;
                end else if (!s[1]) begin
                    if (m_act && !m_kill && acc && !red) begin
                        m_valid = 1; m_inst = mem_word(m_pc); m_idpc = m_pc;
                    end else begin
                        m_valid = 0; m_inst = 0;
                    end
                end
                m_hold = m_act && rdy && !acc;
                if (!m_act) begin
                    m_act = 1;
                end else if (m_kill) begin
                    if (f) m_pend = tgt;
                    if (acc) begin m_pc = m_pend; m_kill = 0; end
                end else if (red) begin
                    if (acc) m_pc = tgt;
                    else begin m_pend = tgt; m_kill = 1; end
                end else if (acc) begin
                    m_pc = m_pc + 32'd4;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_ex_stall();
        test_branch_kill();
        test_flush_priority();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer for the OpenMIPS five-stage pipeline. Owns the program counter, drives the instruction-memory request/ready handshake, and registers the fetched instruction into the IF/ID boundary. Arbitrates the next-PC source in fixed priority: exception flush, branch redirect, stall, sequential. Generates the per-stage stall vector consumed by the pipeline registers.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_req_id  in  1  ID-stage stall request
- stall_req_ex  in  1  EX-stage stall request (multi-cycle op)
- branch_flag_i  in  1  ID-resolved taken branch/jump
- branch_target_i  in  32  branch destination
- flush_i  in  1  exception/eret flush
- new_pc_i  in  32  flush destination (vector or EPC)
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, equals pc_o
- imem_ready_i  in  1  memory has data for current request
- imem_data_i  in  32  instruction word, valid with imem_ready_i
- pc_o  out  32  current fetch PC
- id_pc_o  out  32  PC of instruction presented to ID
- inst_o  out  32  instruction presented to ID
- inst_valid_o  out  1  inst_o is a real instruction (0 = bubble)
- stall_o  out  6  stall vector {wb,mem,ex,id,if,pc}, bit 0 = pc

## Operation
- States: IDLE, REQ, KILL.
- IDLE: entered on reset; imem_req_o=0; next cycle -> REQ unconditionally.
- REQ: imem_req_o=1, imem_addr_o=pc_o. Handshake accepts when imem_ready_i=1 and stall_o[1]=0.
  - Accept, no redirect: inst_o<=imem_data_i, id_pc_o<=pc_o, inst_valid_o<=1, pc_o<=pc_o+4; stay REQ (back-to-back fetch).
  - Accept with redirect same cycle: data discarded, inst_valid_o<=0, pc_o<=target; stay REQ.
  - Redirect without ready: request cannot be withdrawn; pc_o/imem_addr_o held, target stored in pending register; -> KILL.
- KILL: imem_req_o=1 at old address. On imem_ready_i: data discarded, inst_valid_o<=0, pc_o<=pending; -> REQ. A flush in KILL overwrites pending; a branch in KILL is ignored.
- Redirect priority: flush_i (target new_pc_i) > branch_flag_i (target branch_target_i). branch_flag_i honored only when stall_o[2]=0. Targets have bits [1:0] forced to 00.
- Stall vector (first match): flush_i -> 6'b000000; stall_req_ex -> 6'b001111; stall_req_id -> 6'b000111; REQ/KILL without imem_ready_i -> 6'b000011; else 6'b000000.
- IF/ID register: stall_o[1]=1 and stall_o[2]=1 -> hold inst_o/id_pc_o/inst_valid_o; stall_o[1]=1 and stall_o[2]=0 -> bubble (inst_valid_o<=0, inst_o<=0); flush_i -> bubble.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 -> 32'h0000_0000.
- Memory contract: while imem_req_o=1, imem_addr_o is stable; memory holds imem_ready_i/imem_data_i until accepted or imem_req_o drops.

## Timing
- Reset values: pc_o=RESET_PC, imem_req_o=0, id_pc_o=0, inst_o=0, inst_valid_o=0, stall_o=0, state IDLE, pending=0.
- Reset mid-request: imem_req_o=0 the cycle after rst sampled high; outstanding data ignored.
- First request: imem_req_o=1 on 2nd cycle after rst deasserts.
- Zero-wait memory: one instruction per cycle; inst_valid_o rises the cycle after ready sampled.
- Redirect latency: new target on imem_addr_o the cycle after acceptance (REQ) or after ready (KILL).
- stall_o is combinational from current inputs/state; all other outputs registered.

## Test plan
- Reset, RESET_PC=0, ready tied 1 -> imem_addr_o 0,4,8,C on consecutive cycles from cycle 2; inst_valid_o=1 from cycle 3.
- ready low 3 cycles at addr 0x10 -> addr held 0x10, stall_o=6'b000011, inst_valid_o=0 for 3 cycles, then 0x14.
- stall_req_ex 2 cycles with ready=1 -> stall_o=6'b001111, pc_o and inst_o held, no acceptance; resumes sequentially.
- branch_flag_i target 0x100 while ready=0 at 0x20 -> KILL; ready after 2 cycles -> data discarded, next addr 0x100; branch_target 0x103 -> 0x100.
- flush_i new_pc 0x180 same cycle as branch_flag_i 0x200 -> next addr 0x180, stall_o=0, inst_valid_o=0.
- pc_o=0xFFFFFFFC accepted -> next addr 0x00000000; rst asserted mid-wait -> imem_req_o=0 next cycle, pc_o=RESET_PC.
